// File: rtl/riscv_pkg.sv
// Shared instruction-memory sizing and loader state encoding.
// Also imported by the instruction memory so both sides agree on depth.
package riscv_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_AW    = 8;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_RECV  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source plus memory write port.
interface imem_loader_if;

  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, we, waddr, wdata
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, we, waddr, wdata
  );

endinterface

// File: rtl/byte_packer.sv
// Byte counter and little-endian 4-byte assemble register.
// Bytes shift in from the top, so the first byte ends up in word_o[7:0].
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (accept_i) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = {byte_i, word_q[31:8]};
    end
  end

  assign last_o = (cnt_q == 2'd3);
  assign word_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory word by word while holding the CPU.
//
// state    | meaning
// ---------+-------------------------------------------------
// LD_IDLE  | waiting for start, CPU released
// LD_RECV  | accepting bytes of the current word
// LD_WRITE | one-cycle write strobe of the assembled word
// LD_DONE  | one-cycle done pulse, CPU still held
module imem_loader
  import riscv_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   word_count,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  loader_state_e state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   count_clamped;
  logic [AW:0]   idx_next;

  logic          pk_clear, pk_accept, pk_last;
  logic [31:0]   pk_word;

  logic          ready_o, we_o;
  logic [31:0]   waddr_o, wdata_o;

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (pk_clear),
    .accept_i (pk_accept),
    .byte_i   (bus.byte_in),
    .last_o   (pk_last),
    .word_o   (pk_word)
  );

  assign count_clamped = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  assign idx_next      = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LD_IDLE;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    pk_clear  = 1'b0;
    pk_accept = 1'b0;
    ready_o   = 1'b0;
    we_o      = 1'b0;
    waddr_o   = '0;
    wdata_o   = '0;
    cpu_hold  = 1'b0;
    done      = 1'b0;

    case (state_q)
      LD_IDLE: begin
        if (start) begin
          count_d  = count_clamped;
          idx_d    = '0;
          pk_clear = 1'b1;
          state_d  = (count_clamped == '0) ? LD_DONE : LD_RECV;
        end
      end
      LD_RECV: begin
        ready_o   = 1'b1;
        cpu_hold  = 1'b1;
        pk_accept = bus.byte_valid;
        if (bus.byte_valid && pk_last) state_d = LD_WRITE;
      end
      LD_WRITE: begin
        we_o                = 1'b1;
        cpu_hold            = 1'b1;
        wdata_o             = pk_word;
        waddr_o[AW+1:2]     = idx_q[AW-1:0];
        idx_d               = idx_next;
        pk_clear            = 1'b1;
        state_d             = (idx_next == count_q) ? LD_DONE : LD_RECV;
      end
      LD_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b1;
        state_d  = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase

    // Outputs are forced low for the whole reset cycle, not just after the edge.
    if (reset) begin
      pk_accept = 1'b0;
      ready_o   = 1'b0;
      we_o      = 1'b0;
      waddr_o   = '0;
      wdata_o   = '0;
      cpu_hold  = 1'b0;
      done      = 1'b0;
    end
  end

  assign bus.byte_ready = ready_o;
  assign bus.we         = we_o;
  assign bus.waddr      = waddr_o;
  assign bus.wdata      = wdata_o;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, throttled, empty, aborted,
// start-during-load and over-depth loads.
module tb_imem_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [8:0] word_count;
  logic       cpu_hold;
  logic       done;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(256), .AW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/done log and CPU-hold gap tracker, sampled just after each rising edge.
  int          cyc = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wcyc_q[$];
  int          dcyc_q[$];
  bit          loading = 1'b0;
  int          hold_gaps = 0;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus.we) begin
      wa_q.push_back(bus.waddr);
      wd_q.push_back(bus.wdata);
      wcyc_q.push_back(cyc);
    end
    if (done) dcyc_q.push_back(cyc);
    if (reset) loading = 1'b0;
    if (start && !reset) loading = 1'b1;
    if (loading && !cpu_hold) hold_gaps++;
    if (done) loading = 1'b0;
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wcyc_q.delete();
    dcyc_q.delete();
    hold_gaps = 0;
  endtask

  task automatic pulse_start(input logic [8:0] wc);
    @(negedge clk);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] data[$], input bit toggle, input int limit);
    int idx = 0;
    int n = 0;
    bit v;
    while (idx < data.size() && n < limit) begin
      @(negedge clk);
      n++;
      v = toggle ? n[0] : 1'b1;
      bus.byte_valid = v;
      bus.byte_in    = data[idx];
      if (v && bus.byte_ready) idx++;
    end
    checks++;
    if (idx != data.size()) begin
      errors++;
      $display("FAIL send_bytes: accepted %0d bytes, required %0d", idx, data.size());
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    start          = 1'b1;
    word_count     = 9'd2;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hAA;
    repeat (2) @(negedge clk);
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b want 0", bus.byte_ready); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.we); end
    checks++; if (bus.waddr !== 32'd0) begin errors++; $display("FAIL reset_waddr: got %h want 0", bus.waddr); end
    checks++; if (bus.wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.wdata); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_cpu_hold: got %b want 0", cpu_hold); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    reset          = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    #1;
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_priority_hold: got %b want 0", cpu_hold); end
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_priority_ready: got %b want 0", bus.byte_ready); end
  endtask

  task automatic check_two_words(input string name);
    checks++; if (wa_q.size() != 2) begin errors++; $display("FAIL %s_writes: got %0d want 2", name, wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wa_q[0] !== 32'h0) begin errors++; $display("FAIL %s_waddr0: got %h want 00000000", name, wa_q[0]); end
      checks++; if (wd_q[0] !== 32'h00500013) begin errors++; $display("FAIL %s_wdata0: got %h want 00500013", name, wd_q[0]); end
      checks++; if (wa_q[1] !== 32'h4) begin errors++; $display("FAIL %s_waddr1: got %h want 00000004", name, wa_q[1]); end
      checks++; if (wd_q[1] !== 32'h00100093) begin errors++; $display("FAIL %s_wdata1: got %h want 00100093", name, wd_q[1]); end
      checks++;
      if (dcyc_q.size() != 1 || dcyc_q[0] != wcyc_q[1] + 1) begin
        errors++;
        $display("FAIL %s_done_timing: done count %0d, want one pulse 1 cycle after write at %0d", name, dcyc_q.size(), wcyc_q[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prog[$];
    prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    clear_log();
    pulse_start(9'd2);
    send_bytes(prog, 1'b0, 50);
    wait_done("b2b_done", 10);
    @(negedge clk);
    check_two_words("b2b");
    if (wcyc_q.size() == 2) begin
      checks++; if (wcyc_q[1] - wcyc_q[0] != 5) begin errors++; $display("FAIL b2b_throughput: got %0d cycles want 5", wcyc_q[1] - wcyc_q[0]); end
    end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL b2b_hold_release: got %b want 0", cpu_hold); end
  endtask

  task automatic test_toggle_valid();
    logic [7:0] prog[$];
    prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    clear_log();
    pulse_start(9'd2);
    send_bytes(prog, 1'b1, 80);
    wait_done("toggle_done", 10);
    @(negedge clk);
    check_two_words("toggle");
    checks++; if (hold_gaps != 0) begin errors++; $display("FAIL toggle_hold_gaps: got %0d want 0", hold_gaps); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL toggle_hold_release: got %b want 0", cpu_hold); end
  endtask

  task automatic test_zero_count();
    clear_log();
    @(negedge clk);
    start      = 1'b1;
    word_count = 9'd0;
    @(negedge clk);
    start      = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL zero_ready: got %b want 0", bus.byte_ready); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b want 0", done); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_hold: got %b want 0", cpu_hold); end
    repeat (3) @(negedge clk);
    checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wa_q.size()); end
  endtask

  task automatic test_abort();
    logic [7:0] part[$];
    logic [7:0] one[$];
    part = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00};
    one  = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    pulse_start(9'd3);
    send_bytes(part, 1'b0, 50);
    reset          = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hEE;
    #1;
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_in_reset: got %b want 0", bus.byte_ready); end
    @(negedge clk);
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL abort_hold: got %b want 0", cpu_hold); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL abort_we: got %b want 0", bus.we); end
    reset          = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", cpu_hold); end
    checks++; if (wa_q.size() != 1) begin errors++; $display("FAIL abort_writes: got %0d want 1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      checks++; if (wa_q[0] !== 32'h0) begin errors++; $display("FAIL abort_waddr: got %h want 00000000", wa_q[0]); end
    end
    pulse_start(9'd1);
    send_bytes(one, 1'b0, 50);
    wait_done("abort_reload_done", 10);
    checks++; if (wa_q.size() != 2) begin errors++; $display("FAIL reload_writes: got %0d want 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wa_q[1] !== 32'h0) begin errors++; $display("FAIL reload_waddr: got %h want 00000000", wa_q[1]); end
      checks++; if (wd_q[1] !== 32'h44332211) begin errors++; $display("FAIL reload_wdata: got %h want 44332211", wd_q[1]); end
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] p0[$];
    logic [7:0] p1[$];
    p0 = '{8'h13, 8'h00};
    p1 = '{8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    clear_log();
    pulse_start(9'd2);
    send_bytes(p0, 1'b0, 20);
    start      = 1'b1;
    word_count = 9'd1;
    @(negedge clk);
    start      = 1'b0;
    send_bytes(p1, 1'b0, 50);
    wait_done("ignored_done", 10);
    @(negedge clk);
    check_two_words("ignored");
  endtask

  task automatic test_clamp();
    logic [7:0] prog[$];
    for (int w = 0; w < 256; w++) begin
      prog.push_back(8'(w));
      prog.push_back(8'hA5);
      prog.push_back(8'h5A);
      prog.push_back(8'hC3);
    end
    clear_log();
    pulse_start(9'd300);
    send_bytes(prog, 1'b0, 3000);
    wait_done("clamp_done", 10);
    repeat (10) @(negedge clk);
    checks++; if (wa_q.size() != 256) begin errors++; $display("FAIL clamp_writes: got %0d want 256", wa_q.size()); end
    if (wa_q.size() == 256) begin
      checks++; if (wa_q[255] !== 32'h3FC) begin errors++; $display("FAIL clamp_last_waddr: got %h want 000003fc", wa_q[255]); end
      checks++; if (wd_q[255] !== 32'hC35AA5FF) begin errors++; $display("FAIL clamp_last_wdata: got %h want c35aa5ff", wd_q[255]); end
      checks++; if (wd_q[0] !== 32'hC35AA500) begin errors++; $display("FAIL clamp_first_wdata: got %h want c35aa500", wd_q[0]); end
    end
    checks++; if (dcyc_q.size() != 1) begin errors++; $display("FAIL clamp_done_count: got %0d want 1", dcyc_q.size()); end
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    word_count     = 9'd0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    test_reset();
    test_back_to_back();
    test_toggle_valid();
    test_zero_count();
    test_abort();
    test_start_ignored();
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
